fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting directly upstream of the 4096x4 RAM. It holds the program counter, drives the RAM's `addr`/`read` lines one nibble per cycle, and assembles `NIBBLES` consecutive 4-bit words into one instruction. It presents that instruction to the decoder over a valid/ready handshake and supports jump redirection and halting. It never writes RAM; the RAM `write` port is driven by other logic.

## Interface
- `ADDR_WIDTH`, 12, RAM address width.
- `NIBBLES`, 4, nibbles per instruction; instruction width = 4*NIBBLES.
- `RESET_PC`, 0, first fetch address after reset.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `ram_read`  out  1  RAM read enable.
- `ram_addr`  out  ADDR_WIDTH  RAM address.
- `ram_data`  in  4  RAM `out`; combinational in the same cycle as `ram_addr`.
- `instr`  out  4*NIBBLES  assembled instruction.
- `instr_pc`  out  ADDR_WIDTH  address of the instruction's first nibble.
- `instr_valid`  out  1  `instr`/`instr_pc` valid.
- `instr_ready`  in  1  decoder accepts.
- `jump`  in  1  redirect request, one-cycle pulse or level.
- `jump_addr`  in  ADDR_WIDTH  redirect target.
- `halt`  in  1  level; stop fetching at the next instruction boundary.
- `busy`  out  1  a nibble read is in progress this cycle.

## Operation
- Registers:
  - `fetch_addr` (ADDR_WIDTH).
  - `start_addr` (ADDR_WIDTH).
  - `cnt` (0..NIBBLES-1).
  - `shift` (4*NIBBLES).
  - state: FETCH, HOLD, HALTED.
- Reset (async, immediate):
  - state=FETCH, `fetch_addr`=`start_addr`=RESET_PC, `cnt`=0.
  - `instr`=0, `instr_pc`=RESET_PC, `instr_valid`=0.
  - While `rst` is high: `ram_read`=0, `busy`=0.
- FETCH:
  - `ram_read`=1, `ram_addr`=`fetch_addr`, `busy`=1.
  - Each edge: `shift`={`shift`[lower], `ram_data`}, `fetch_addr`+=1 (wraps 0xFFF→0x000), `cnt`+=1.
  - Nibble order is big-endian: the lowest address lands in `instr`[4*NIBBLES-1 -: 4].
  - On `cnt`==NIBBLES-1: load `instr` from the completed shift, set `instr_pc`=`start_addr` and `instr_valid`=1, then go to HOLD.
- HOLD:
  - `ram_read`=0, `ram_addr` holds its last value, `busy`=0.
  - `instr` and `instr_pc` are stable while valid.
  - When `instr_valid` && `instr_ready`: `instr_valid`=0, `cnt`=0, `start_addr`=`fetch_addr`.
  - After that handshake, go to HALTED if `halt`=1, else FETCH.
- HALTED:
  - `ram_read`=0, `busy`=0.
  - When `halt`=0, go to FETCH at `fetch_addr` on the next edge.
- `halt` in FETCH does not abort the fetch; the current instruction completes and is handed off first.
- `jump` has highest priority in every state:
  - `fetch_addr`=`start_addr`=`jump_addr`, `cnt`=0.
  - Any partial shift is discarded; no valid is produced for it.
  - A held, untransferred instruction is dropped (`instr_valid`=0).
  - Next state is FETCH, or HALTED if `halt`=1.
- Jump in the same cycle as a handshake: the transfer counts (the decoder consumed it) and the redirect also applies.
- Jump on the final FETCH nibble: the completed instruction is discarded; `instr_valid` stays 0.
- The address wrap is pure modulo 2^ADDR_WIDTH; instructions may straddle 0xFFF→0x000.

## Timing
- Latency: FETCH entered at edge E; `instr_valid` is high after edge E+NIBBLES.
- With `instr_ready` held at 1: one instruction per NIBBLES+1 cycles (5 by default).
- `ram_addr`/`ram_read` come from registers only, so the RAM sees stable inputs for the whole cycle.
- `instr_valid` deasserts on the edge after the handshake; it never falls without a handshake, jump or reset.
- `halt` and `jump` are sampled on the rising edge; `rst` acts asynchronously at any time, including mid-fetch.

## Test plan
1. **Basic fetch.** RAM[0..3]=1,2,3,4, `instr_ready`=1, release `rst` → `ram_addr`=0,1,2,3 on consecutive cycles with `ram_read`=1. Then `instr_valid`=1, `instr`=0x1234, `instr_pc`=0x000. The next fetch starts at 0x004.
2. **Backpressure.** `instr_ready`=0 for 10 cycles after valid → `instr`=0x1234 held stable, `ram_read`=0, `busy`=0. Raise ready → exactly one transfer; fetch resumes at 0x004.
3. **Wrap-around.** Jump to 0xFFE with RAM[FFE,FFF,000,001]=A,B,C,D → `instr`=0xABCD, `instr_pc`=0xFFE. The next fetch begins at 0x002.
4. **Jump mid-fetch.** Pulse `jump` (`jump_addr`=0x100) after 2 nibbles → no valid for the old instruction; next `ram_addr`=0x100; `instr_pc`=0x100.
5. **Jump with handshake, and halt.**
   - Jump to 0x200 in the same cycle as a valid/ready handshake → that instruction is delivered once; the next fetch is from 0x200.
   - Assert `halt` mid-fetch → the current instruction is delivered, then `ram_read` stays 0. Deassert → fetch resumes at the next sequential address.
6. **Async reset mid-fetch.** Assert `rst` between clock edges during FETCH → `instr_valid`, `ram_read` and `busy` go to 0 immediately. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads NIBBLES consecutive 4-bit RAM words per instruction
// and hands the assembled instruction to the decoder over valid/ready.
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 12,
  parameter int unsigned           NIBBLES    = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    ram_read,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  input  logic [3:0]              ram_data,
  output logic [4*NIBBLES-1:0]    instr,
  output logic [ADDR_WIDTH-1:0]   instr_pc,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  input  logic                    jump,
  input  logic [ADDR_WIDTH-1:0]   jump_addr,
  input  logic                    halt,
  output logic                    busy
);

  localparam int unsigned IW = 4 * NIBBLES;
  localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;

  state_t                state, nxt_state;
  logic [ADDR_WIDTH-1:0] fetch_addr, nxt_fetch;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         shift;
  logic [IW-1:0]         assembled;
  logic                  last;
  logic                  handshake;

  assign assembled = {shift[IW-5:0], ram_data};
  assign last      = (cnt == CW'(NIBBLES - 1));
  assign handshake = instr_valid & instr_ready;

  // RAM controls decode straight from the state register; reset forces them idle
  assign ram_read = (state == FETCH) & ~rst;
  assign busy     = (state == FETCH) & ~rst;

  // Next state and fetch address; jump overrides everything
  always_comb begin
    nxt_state = state;
    nxt_fetch = fetch_addr;
    if (jump) begin
      nxt_state = halt ? HALTED : FETCH;
      nxt_fetch = jump_addr;
    end else begin
      case (state)
        FETCH: begin
          nxt_fetch = fetch_addr + ADDR_WIDTH'(1);
          if (last) nxt_state = HOLD;
        end
        HOLD:    if (handshake) nxt_state = halt ? HALTED : FETCH;
        HALTED:  if (!halt) nxt_state = FETCH;
        default: nxt_state = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      fetch_addr  <= RESET_PC;
      start_addr  <= RESET_PC;
      ram_addr    <= RESET_PC;
      cnt         <= '0;
      shift       <= '0;
      instr       <= '0;
      instr_pc    <= RESET_PC;
      instr_valid <= 1'b0;
    end else begin
      state      <= nxt_state;
      fetch_addr <= nxt_fetch;
      // ram_addr only moves when a fetch cycle follows, so it holds while idle
      if (nxt_state == FETCH) ram_addr <= nxt_fetch;
      if (jump) begin
        start_addr  <= jump_addr;
        cnt         <= '0;
        instr_valid <= 1'b0;
      end else begin
        case (state)
          FETCH: begin
            shift <= assembled;
            if (last) begin
              instr       <= assembled;
              instr_pc    <= start_addr;
              instr_valid <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          HOLD: begin
            if (handshake) begin
              instr_valid <= 1'b0;
              cnt         <= '0;
              start_addr  <= fetch_addr;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected instructions,
// a negedge monitor pops and compares on every valid/ready transfer.
module tb_fetch_unit;

  localparam int unsigned AW = 12;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [15:0]   ins;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ram_read;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_data;
  logic [15:0]   instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic          jump;
  logic [AW-1:0] jump_addr;
  logic          halt;
  logic          busy;

  logic [3:0] mem [0:4095];
  exp_t       sb[$];
  exp_t       e;
  int         passed = 0;
  int         total  = 0;
  logic       ok;

  always #5 clk = ~clk;

  assign ram_data = mem[ram_addr];

  fetch_unit #(.ADDR_WIDTH(AW), .NIBBLES(4), .RESET_PC(12'h000)) dut (
    .clk(clk), .rst(rst), .ram_read(ram_read), .ram_addr(ram_addr),
    .ram_data(ram_data), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .jump(jump),
    .jump_addr(jump_addr), .halt(halt), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!instr_valid && n < 20);
    check({name, "_valid"}, 32'(instr_valid), 32'd1);
  endtask

  task automatic push(input logic [AW-1:0] pc, input logic [15:0] ins);
    exp_t x;
    x.pc  = pc;
    x.ins = ins;
    sb.push_back(x);
  endtask

  // Monitor: every transfer must match the oldest expected instruction
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_transfer: got pc=%h instr=%h expected none", instr_pc, instr);
      end else begin
        e = sb.pop_front();
        check("transfer", {4'h0, instr_pc, instr}, {4'h0, e.pc, e.ins});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 4'h0;
    for (int i = 0; i < 16; i++) mem[i] = 4'(i + 1);
    mem[12'h100] = 4'hC; mem[12'h101] = 4'hA; mem[12'h102] = 4'hF; mem[12'h103] = 4'hE;
    mem[12'h200] = 4'hB; mem[12'h201] = 4'hE; mem[12'h202] = 4'hE; mem[12'h203] = 4'hF;
    mem[12'h204] = 4'hD; mem[12'h205] = 4'h0; mem[12'h206] = 4'h0; mem[12'h207] = 4'hD;
    mem[12'h208] = 4'hF; mem[12'h209] = 4'h0; mem[12'h20A] = 4'h0; mem[12'h20B] = 4'hD;
    mem[12'hFFE] = 4'hA; mem[12'hFFF] = 4'hB;

    rst = 1'b1; instr_ready = 1'b0; jump = 1'b0; jump_addr = '0; halt = 1'b0;
    #2;
    check("rst_read", 32'(ram_read), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_pc", 32'(instr_pc), 32'd0);

    // Basic fetch
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    instr_ready = 1'b1;
    push(12'h000, 16'h1234);
    push(12'h004, 16'h5678);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("fetch_addr", 32'(ram_addr), 32'(i));
      check("fetch_read", 32'(ram_read), 32'd1);
      step(1);
    end
    check("basic_valid", 32'(instr_valid), 32'd1);
    check("basic_read_idle", 32'(ram_read), 32'd0);
    step(1);
    check("next_addr", 32'(ram_addr), 32'h004);

    // Backpressure
    instr_ready = 1'b0;
    wait_valid("bp");
    ok = 1'b1;
    repeat (10) begin
      ok &= (instr == 16'h5678) && (instr_pc == 12'h004) && instr_valid && !ram_read && !busy;
      step(1);
    end
    check("bp_hold", 32'(ok), 32'd1);
    instr_ready = 1'b1;
    step(1);
    check("bp_single_xfer", 32'(instr_valid), 32'd0);
    check("bp_resume_addr", 32'(ram_addr), 32'h008);

    // Wrap-around via jump to 0xFFE
    mem[0] = 4'hC; mem[1] = 4'hD;
    jump = 1'b1; jump_addr = 12'hFFE;
    push(12'hFFE, 16'hABCD);
    push(12'h002, 16'h3456);
    step(1);
    jump = 1'b0;
    check("wrap_jump_addr", 32'(ram_addr), 32'hFFE);
    wait_valid("wrap");
    step(1);
    check("wrap_next_addr", 32'(ram_addr), 32'h002);
    wait_valid("seq");

    // Jump after two nibbles of the instruction at 0x006
    step(3);
    instr_ready = 1'b0;
    jump = 1'b1; jump_addr = 12'h100;
    push(12'h100, 16'hCAFE);
    step(1);
    jump = 1'b0;
    check("midjump_addr", 32'(ram_addr), 32'h100);
    check("midjump_no_valid", 32'(instr_valid), 32'd0);
    wait_valid("midjump");

    // Jump in the same cycle as a handshake
    instr_ready = 1'b1;
    jump = 1'b1; jump_addr = 12'h200;
    push(12'h200, 16'hBEEF);
    step(1);
    jump = 1'b0;
    check("jhs_valid_drop", 32'(instr_valid), 32'd0);
    check("jhs_addr", 32'(ram_addr), 32'h200);
    wait_valid("jhs");

    // Halt mid-fetch completes the instruction, then idles
    step(2);
    halt = 1'b1;
    push(12'h204, 16'hD00D);
    push(12'h208, 16'hF00D);
    wait_valid("halt");
    step(1);
    check("halted_read", 32'(ram_read), 32'd0);
    check("halted_busy", 32'(busy), 32'd0);
    ok = 1'b1;
    repeat (5) begin
      ok &= !ram_read && !instr_valid;
      step(1);
    end
    check("halted_idle", 32'(ok), 32'd1);
    halt = 1'b0;
    step(1);
    check("resume_addr", 32'(ram_addr), 32'h208);
    check("resume_read", 32'(ram_read), 32'd1);
    wait_valid("resume");
    step(1);

    // Async reset mid-fetch
    mem[0] = 4'h1; mem[1] = 4'h2;
    step(1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(instr_valid), 32'd0);
    check("arst_read", 32'(ram_read), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    #2;
    rst = 1'b0;
    push(12'h000, 16'h1234);
    #1;
    check("arst_restart_addr", 32'(ram_addr), 32'h000);
    check("arst_restart_read", 32'(ram_read), 32'd1);
    wait_valid("arst");
    step(2);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
